// File: rtl/fir_filter_pkg.sv
// Shared constants, FSM state type and output saturation for the 64-tap
// distributed-arithmetic FIR filter.
package fir_filter_pkg;

  localparam int TAPS      = 64;
  localparam int NBANKS    = 8;
  localparam int BANK_TAPS = 8;
  localparam int DW        = 16;
  localparam int LW        = 20;
  localparam int ACCW      = 40;
  localparam int BANK_AW   = 8;
  localparam int CAW       = 11;
  localparam int BITW      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic signed [ACCW-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACCW-1:0] SAT_MIN = -40'sd32768;

  // Floor-scale the Q15 accumulator back to sample width and clamp.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] shifted;
    shifted = acc >>> (DW - 1);
    if (shifted > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end
    return shifted[DW-1:0];
  endfunction

endpackage

// File: rtl/fir_da_lut.sv
// One 256-word partial-sum bank: synchronous write, combinational read so the
// bit-serial datapath sees the word for the current bit in the same cycle.
module fir_da_lut
  import fir_filter_pkg::*;
(
  input  logic               clk_fast,
  input  logic               we,
  input  logic [BANK_AW-1:0] waddr,
  input  logic [LW-1:0]      wdata,
  input  logic [BANK_AW-1:0] raddr,
  output logic [LW-1:0]      rdata
);

  logic [LW-1:0] mem [2**BANK_AW];

  always_ff @(posedge clk_fast) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_filter.sv
// 64-tap FIR: each accepted sample is folded bit-serially (MSB first) through
// eight partial-sum banks, producing one saturated Q15-scaled result.
module fir_filter #(
  parameter int TAPS = 64,
  parameter int DW   = 16,
  parameter int LW   = 20
) (
  input  logic                 clk_fast,
  input  logic                 reset,
  input  logic signed [DW-1:0] din,
  input  logic                 valid_in,
  input  logic signed [LW-1:0] CIN,
  input  logic [10:0]          CADDR,
  input  logic                 CLOAD,
  output logic signed [DW-1:0] dout,
  output logic                 valid_out
);

  import fir_filter_pkg::*;

  state_e                        state_reg, state_next;
  logic [BITW-1:0]               bit_reg;
  logic signed [ACCW-1:0]        acc_reg, acc_next;
  logic [DW-1:0]                 x_reg  [TAPS];
  logic [DW-1:0]                 tap_in [TAPS];
  logic [NBANKS-1:0][BANK_TAPS-1:0] bank_addr;
  logic [NBANKS-1:0][LW-1:0]     bank_word;
  logic signed [ACCW-1:0]        p_sum;
  logic                          accept;
  logic                          run_step;

  // LUT writes take priority over sample acceptance.
  assign accept   = (state_reg == IDLE) && valid_in && !CLOAD;
  assign run_step = (state_reg == RUN) && !CLOAD;

  genvar gi, gj;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign tap_in[gi] = din;
      end else begin : g_body
        assign tap_in[gi] = x_reg[gi-1];
      end
    end

    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      for (gj = 0; gj < BANK_TAPS; gj++) begin : g_addr
        assign bank_addr[gi][gj] = x_reg[gi*BANK_TAPS + gj][bit_reg];
      end

      fir_da_lut u_lut (
        .clk_fast (clk_fast),
        .we       (CLOAD && (CADDR[10:8] == 3'(gi))),
        .waddr    (CADDR[7:0]),
        .wdata    (CIN),
        .raddr    (bank_addr[gi]),
        .rdata    (bank_word[gi])
      );
    end
  endgenerate

  always_comb begin
    p_sum = '0;
    for (int k = 0; k < NBANKS; k++) begin
      p_sum = p_sum + ACCW'($signed(bank_word[k]));
    end
  end

  // The sign bit carries negative weight, so the first step negates.
  always_comb begin
    acc_next = acc_reg;
    if (run_step) begin
      if (bit_reg == BITW'(DW - 1)) begin
        acc_next = -p_sum;
      end else begin
        acc_next = (acc_reg <<< 1) + p_sum;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (CLOAD) begin
          state_next = IDLE;
        end else if (bit_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state_reg <= IDLE;
      bit_reg   <= '0;
      acc_reg   <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      valid_out <= (state_reg == DONE);
      if (state_reg == DONE) begin
        dout <= scale_sat(acc_reg);
      end
      if (accept) begin
        bit_reg <= BITW'(DW - 1);
        for (int i = 0; i < TAPS; i++) begin
          x_reg[i] <= tap_in[i];
        end
      end else if (run_step) begin
        bit_reg <= bit_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter against a direct dot-product model.
module tb_fir_filter;

  logic               clk_fast = 1'b0;
  logic               reset;
  logic signed [15:0] din;
  logic               valid_in;
  logic signed [19:0] CIN;
  logic [10:0]        CADDR;
  logic               CLOAD;
  logic signed [15:0] dout;
  logic               valid_out;

  always #5 clk_fast = ~clk_fast;

  fir_filter dut (
    .clk_fast  (clk_fast),
    .reset     (reset),
    .din       (din),
    .valid_in  (valid_in),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .dout      (dout),
    .valid_out (valid_out)
  );

  int coef [64];
  int xm   [64];
  int n_checks = 0;
  int n_errors = 0;
  logic signed [15:0] exp_hold = 16'sd0;

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  function automatic int lut_word(input int addr);
    int bank, pat, s;
    bank = addr / 256;
    pat  = addr % 256;
    s    = 0;
    for (int j = 0; j < 8; j++) begin
      if (((pat >> j) & 1) == 1) s += coef[bank*8 + j];
    end
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) xm[i] = 0;
  endfunction

  function automatic void model_shift(input int v);
    for (int i = 63; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = v;
  endfunction

  function automatic logic signed [15:0] model_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < 64; i++) acc += longint'(coef[i]) * longint'(xm[i]);
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic load_lut(input bit with_valid);
    for (int a = 0; a < 2048; a++) begin
      CLOAD    = 1'b1;
      CADDR    = 11'(a);
      CIN      = 20'(lut_word(a));
      valid_in = with_valid;
      din      = 16'($urandom);
      tick();
    end
    CLOAD    = 1'b0;
    valid_in = 1'b0;
  endtask

  // Issue one sample from IDLE; returns the edge offset of valid_out (0 = none).
  task automatic send(input logic signed [15:0] v, output int lat, output logic signed [15:0] res);
    din      = v;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    lat = 0;
    res = dout;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (valid_out && lat == 0) begin
        lat = k;
        res = dout;
      end
    end
  endtask

  task automatic check_sample(input string name, input int idx, input logic signed [15:0] v,
                              input logic signed [15:0] expv);
    int lat;
    logic signed [15:0] res;
    send(v, lat, res);
    $display("%s %0d: din=%0d dout=%0d expected=%0d latency=%0d", name, idx, v, res, expv, lat);
    n_checks++;
    if (lat !== 17) begin
      n_errors++;
      $display("FAIL %s_latency[%0d]: got %0d, want 17", name, idx, lat);
    end
    n_checks++;
    if (res !== expv) begin
      n_errors++;
      $display("FAIL %s_dout[%0d]: got %0d, want %0d", name, idx, res, expv);
    end
    exp_hold = expv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din      = 16'($urandom);
      valid_in = 1'($urandom);
      CLOAD    = 1'($urandom);
      CADDR    = 11'($urandom);
      CIN      = 20'($urandom);
      tick();
    end
    n_checks++;
    if (dout !== 16'sd0) begin
      n_errors++;
      $display("FAIL reset_dout: got %0d, want 0", dout);
    end
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid: got %b, want 0", valid_out);
    end
    reset = 1'b0; valid_in = 1'b0; CLOAD = 1'b0;
    model_clear();
    exp_hold = 16'sd0;
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 64; i++) coef[i] = 2 * (i + 1);
    load_lut(1'b0);
    for (int n = 0; n < 71; n++) begin
      logic signed [15:0] v;
      v = (n == 0) ? 16'sd16384 : 16'sd0;
      model_shift(v);
      check_sample("impulse", n, v, (n < 64) ? 16'(n + 1) : 16'sd0);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    din = 16'($urandom); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid_out) cnt++;
    end
    $display("reset_mid: valid_out pulses=%0d dout=%0d", cnt, dout);
    n_checks++;
    if (cnt !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_valid: got %0d pulses, want 0", cnt);
    end
    n_checks++;
    if (dout !== 16'sd0) begin
      n_errors++;
      $display("FAIL reset_mid_dout: got %0d, want 0", dout);
    end
    model_clear();
    exp_hold = 16'sd0;
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 64; i++) coef[i] = 0;
    coef[0] = 32767;
    load_lut(1'b0);
    model_shift(-32768);
    check_sample("extreme_pos_coef", 0, -16'sd32768, -16'sd32767);
    coef[0] = -32768;
    load_lut(1'b0);
    model_shift(-32768);
    check_sample("extreme_sat", 0, -16'sd32768, 16'sd32767);
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) coef[i] = int'($signed(16'($urandom)));
    load_lut(1'b1);
    for (int n = 0; n < 50; n++) begin
      logic signed [15:0] v;
      v = 16'($urandom);
      model_shift(v);
      check_sample("random", n, v, model_out());
    end
  endtask

  task automatic test_busy_drop();
    int cnt;
    logic signed [15:0] v1, res;
    v1 = 16'($urandom);
    din = v1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    din = 16'($urandom); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    model_shift(v1);
    cnt = 0;
    res = 16'sd0;
    for (int k = 6; k <= 40; k++) begin
      tick();
      if (valid_out) begin
        cnt++;
        res = dout;
      end
    end
    $display("busy_drop: pulses=%0d dout=%0d expected=%0d", cnt, res, model_out());
    n_checks++;
    if (cnt !== 1) begin
      n_errors++;
      $display("FAIL busy_drop_pulses: got %0d, want 1", cnt);
    end
    n_checks++;
    if (res !== model_out()) begin
      n_errors++;
      $display("FAIL busy_drop_dout: got %0d, want %0d", res, model_out());
    end
    v1 = 16'($urandom);
    model_shift(v1);
    check_sample("busy_follow", 0, v1, model_out());
  endtask

  task automatic test_abort();
    int cnt, a;
    logic signed [15:0] v;
    v = 16'($urandom);
    din = v; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    a = int'($urandom_range(0, 2047));
    CLOAD = 1'b1; CADDR = 11'(a); CIN = 20'(lut_word(a));
    tick();
    CLOAD = 1'b0;
    model_shift(v);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (valid_out) cnt++;
    end
    $display("abort: pulses=%0d dout=%0d held=%0d", cnt, dout, exp_hold);
    n_checks++;
    if (cnt !== 0) begin
      n_errors++;
      $display("FAIL abort_valid: got %0d pulses, want 0", cnt);
    end
    n_checks++;
    if (dout !== exp_hold) begin
      n_errors++;
      $display("FAIL abort_dout_hold: got %0d, want %0d", dout, exp_hold);
    end
    v = 16'($urandom);
    model_shift(v);
    check_sample("abort_follow", 0, v, model_out());
  endtask

  initial begin
    reset = 1'b1; din = '0; valid_in = 1'b0; CIN = '0; CADDR = '0; CLOAD = 1'b0;
    test_reset();
    test_impulse();
    test_reset_mid();
    test_extremes();
    test_random();
    test_busy_drop();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
